// File: rtl/npc_ras_unit.sv
// Next-PC unit for the MIPS core: PC register, branch/jump target selection and a
// circular return-address stack for JAL/RET with stall hold and flush.
module npc_ras_unit #(
    parameter int          WIDTH     = 32,
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ras_flush,
    input  logic [2:0]       npc_sel,
    input  logic             zero,
    input  logic             neg,
    input  logic [25:0]      imme,
    input  logic [WIDTH-1:0] rs,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_4,
    output logic [WIDTH-1:0] npc,
    output logic             ras_hit,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             misalign
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BEQ  = 3'd1,
        SEL_BNEG = 3'd2,
        SEL_J    = 3'd3,
        SEL_JAL  = 3'd4,
        SEL_JR   = 3'd5,
        SEL_RET  = 3'd6,
        SEL_RSV  = 3'd7
    } npc_sel_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic signed [17:0] off_s;
    logic [WIDTH-1:0]   off;
    logic [WIDTH-1:0]   br_tgt;
    logic [WIDTH-1:0]   j_tgt;
    logic [WIDTH-1:0]   rs_tgt;
    logic [PW-1:0]      top_idx;
    logic               push, pop;
    npc_sel_e           sel;

    assign sel       = npc_sel_e'(npc_sel);
    assign pc        = pc_q;
    assign pc_4      = pc_q + WIDTH'(4);
    assign off_s     = {imme[15:0], 2'b00};
    assign off       = WIDTH'(off_s);
    assign br_tgt    = pc_4 + off;
    assign j_tgt     = {pc_4[WIDTH-1:28], imme, 2'b00};
    assign rs_tgt    = {rs[WIDTH-1:2], 2'b00};
    // ptr_q is the next write slot, so the most recent entry sits one below it.
    assign top_idx   = ptr_q - PW'(1);

    assign ras_empty    = (cnt_q == '0);
    assign ras_full     = (cnt_q == (PW+1)'(RAS_DEPTH));
    assign ras_overflow = ovf_q;

    always_comb begin
        npc      = pc_4;
        ras_hit  = 1'b0;
        misalign = 1'b0;
        case (sel)
            SEL_BEQ:  npc = zero ? br_tgt : pc_4;
            SEL_BNEG: npc = neg ? br_tgt : pc_4;
            SEL_J,
            SEL_JAL:  npc = j_tgt;
            SEL_JR: begin
                npc      = rs_tgt;
                misalign = |rs[1:0];
            end
            SEL_RET: begin
                if (!ras_empty) begin
                    npc     = ras_q[top_idx];
                    ras_hit = 1'b1;
                end else begin
                    npc      = rs_tgt;
                    misalign = |rs[1:0];
                end
            end
            default:  npc = pc_4;
        endcase
    end

    // Flush wins over any push/pop; stall freezes PC and stack alike.
    always_comb begin
        push  = !stall && !ras_flush && (sel == SEL_JAL);
        pop   = !stall && !ras_flush && (sel == SEL_RET) && !ras_empty;
        pc_d  = stall ? pc_q : npc;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = push && ras_full;
        if (ras_flush) begin
            cnt_d = '0;
        end else if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (!ras_full) cnt_d = cnt_q + (PW+1)'(1);
        end else if (pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= WIDTH'(RESET_PC);
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // When full, the write slot is the oldest entry, giving the circular overwrite.
    always_ff @(posedge clk) begin
        if (push) ras_q[ptr_q] <= pc_4;
    end

endmodule

// File: tb/tb_npc_ras_unit.sv
// Scoreboard bench for npc_ras_unit: directed cycles queue expected outputs,
// a negedge monitor pops and compares them.
module tb_npc_ras_unit;

    localparam int F_PC = 0, F_PC4 = 1, F_NPC = 2, F_HIT = 3;
    localparam int F_EMPTY = 4, F_FULL = 5, F_OVF = 6, F_MIS = 7;
    localparam logic [2:0] SEQ = 3'd0, BEQ = 3'd1, BNEG = 3'd2, J = 3'd3;
    localparam logic [2:0] JAL = 3'd4, JR = 3'd5, RET = 3'd6;

    typedef struct {
        string       name;
        int          fld;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, ras_flush, zero, neg;
    logic [2:0]  npc_sel;
    logic [25:0] imme;
    logic [31:0] rs;
    logic [31:0] pc, pc_4, npc;
    logic        ras_hit, ras_empty, ras_full, ras_overflow, misalign;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    npc_ras_unit #(.WIDTH(32), .RAS_DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .ras_flush(ras_flush),
        .npc_sel(npc_sel), .zero(zero), .neg(neg), .imme(imme), .rs(rs),
        .pc(pc), .pc_4(pc_4), .npc(npc), .ras_hit(ras_hit),
        .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_overflow(ras_overflow), .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(int f);
        case (f)
            F_PC:    return pc;
            F_PC4:   return pc_4;
            F_NPC:   return npc;
            F_HIT:   return {31'd0, ras_hit};
            F_EMPTY: return {31'd0, ras_empty};
            F_FULL:  return {31'd0, ras_full};
            F_OVF:   return {31'd0, ras_overflow};
            default: return {31'd0, misalign};
        endcase
    endfunction

    // Monitor: outputs are presented every cycle; sample at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.fld);
            n_checks++;
            if (a !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
            end
        end
    end

    task automatic expect_v(input string n, input int f, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.fld  = f;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic fl, input logic [2:0] sel,
                         input logic [25:0] im, input logic [31:0] r);
        stall = s; ras_flush = fl; npc_sel = sel; imme = im; rs = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; zero = 1'b0; neg = 1'b0;
        drive(1'b0, 1'b0, SEQ, 26'd0, 32'd0);
        cyc();
        expect_v("rst_pc", F_PC, 32'h3000);
        expect_v("rst_pc4", F_PC4, 32'h3004);
        expect_v("rst_empty", F_EMPTY, 1);
        expect_v("rst_ovf", F_OVF, 0);

        // Branch arithmetic, held by stall so pc stays at 0x3000
        cyc(); rst = 1'b0;
        drive(1'b1, 1'b0, BEQ, 26'h000FFFE, 0); zero = 1'b1;
        expect_v("beq_neg_off", F_NPC, 32'h2FFC);
        cyc(); zero = 1'b0;
        expect_v("beq_not_taken", F_NPC, 32'h3004);
        cyc(); drive(1'b1, 1'b0, BNEG, 26'h0000003, 0); neg = 1'b1;
        expect_v("bneg_taken", F_NPC, 32'h3010);
        expect_v("stall_pc_hold", F_PC, 32'h3000);
        cyc(); neg = 1'b0; zero = 1'b1;
        drive(1'b0, 1'b0, BEQ, 26'h000FFFF, 0);
        expect_v("beq_self", F_NPC, 32'h3000);

        // JAL then RET
        cyc(); zero = 1'b0;
        expect_v("beq_self_pc", F_PC, 32'h3000);
        drive(1'b0, 1'b0, JAL, 26'h0000C10, 0);
        expect_v("jal_npc", F_NPC, 32'h3040);
        expect_v("jal_hit", F_HIT, 0);
        cyc(); drive(1'b0, 1'b0, RET, 26'd0, 0);
        expect_v("jal_pc", F_PC, 32'h3040);
        expect_v("ret_npc", F_NPC, 32'h3004);
        expect_v("ret_hit", F_HIT, 1);
        expect_v("ras_nonempty", F_EMPTY, 0);
        cyc(); drive(1'b0, 1'b0, SEQ, 26'd0, 0);
        expect_v("ret_pc", F_PC, 32'h3004);
        expect_v("ret_empty", F_EMPTY, 1);
        expect_v("seq_npc", F_NPC, 32'h3008);
        cyc(); drive(1'b0, 1'b0, J, 26'h0000C00, 0);
        expect_v("j_npc", F_NPC, 32'h3000);

        // Five nested JALs into a depth-4 stack
        for (int i = 0; i < 5; i++) begin
            cyc();
            drive(1'b0, 1'b0, JAL, 26'((32'h3100 + 32'h100 * i) >> 2), 0);
            expect_v("nest_pc", F_PC, 32'h3000 + 32'h100 * i);
            expect_v("nest_full", F_FULL, (i == 4) ? 32'd1 : 32'd0);
            expect_v("nest_ovf", F_OVF, 0);
        end
        cyc(); drive(1'b0, 1'b0, RET, 26'd0, 32'h8000);
        expect_v("ovf_pulse", F_OVF, 1);
        expect_v("ovf_full", F_FULL, 1);
        expect_v("ret1", F_NPC, 32'h3404);
        cyc();
        expect_v("ovf_clear", F_OVF, 0);
        expect_v("ret2", F_NPC, 32'h3304);
        cyc(); expect_v("ret3", F_NPC, 32'h3204);
        cyc(); expect_v("ret4", F_NPC, 32'h3104);
        expect_v("ret4_hit", F_HIT, 1);

        // Empty RAS falls back to rs
        cyc(); drive(1'b0, 1'b0, RET, 26'd0, 32'h4007);
        expect_v("ret5_pc", F_PC, 32'h3104);
        expect_v("ret5_npc", F_NPC, 32'h4004);
        expect_v("ret5_hit", F_HIT, 0);
        expect_v("ret5_mis", F_MIS, 1);
        cyc(); drive(1'b0, 1'b0, JR, 26'd0, 32'h4000);
        expect_v("jr_npc", F_NPC, 32'h4000);
        expect_v("jr_mis", F_MIS, 0);
        cyc(); drive(1'b0, 1'b0, J, 26'h0000C00, 0);
        expect_v("jr_pc", F_PC, 32'h4000);

        // Stall, flush and reset mid-stall
        cyc(); drive(1'b1, 1'b0, JAL, 26'h0000C10, 0);
        expect_v("stall_jal_npc", F_NPC, 32'h3040);
        cyc(); drive(1'b0, 1'b0, JAL, 26'h0000C00, 0);
        expect_v("stall_jal_pc", F_PC, 32'h3000);
        expect_v("stall_jal_empty", F_EMPTY, 1);
        cyc();
        expect_v("push1_empty", F_EMPTY, 0);
        cyc(); drive(1'b1, 1'b1, SEQ, 26'd0, 0);
        expect_v("push2_full", F_FULL, 0);
        cyc(); drive(1'b0, 1'b0, SEQ, 26'd0, 0);
        expect_v("flush_empty", F_EMPTY, 1);
        expect_v("flush_pc", F_PC, 32'h3000);
        cyc(); drive(1'b1, 1'b0, SEQ, 26'd0, 0);
        expect_v("pre_rst_pc", F_PC, 32'h3004);
        cyc(); rst = 1'b1;
        expect_v("mid_stall_rst_pc", F_PC, 32'h3000);
        cyc(); rst = 1'b0; stall = 1'b0;
        expect_v("post_rst_pc", F_PC, 32'h3000);
        expect_v("post_rst_empty", F_EMPTY, 1);

        cyc(); cyc();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
